completion_queue: RTL and testbench

- Back end of instruction dispatch.
- Records each dispatched instruction's target unit (ALU/MDU/FPU/MEM) and destination in program order.
- Accepts results from the four execution units through per-unit valid/ready handshakes and retires them strictly in dispatch order onto one registered writeback port.
- Sits between the Decode-stage dispatch logic and the integer/FP register-file write ports.

---
 rtl/completion_queue_if.sv | 55 +++++
 rtl/completion_queue.sv | 163 ++++++++++++++++
 tb/tb_completion_queue.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/completion_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : completion_queue_pkg / completion_queue_if
// Description : Core configuration type and the bundle of handshake signals
//               between dispatch, the execution units, the completion queue
//               and the register-file writeback.
//               Modport slave  : the completion queue itself.
//               Modport master : dispatch / execution units / writeback side.
//               Signals:
//                 Flush                      - synchronous queue clear
//                 DispValid/DispReady        - dispatch handshake
//                 DispUnit/DispRd/DispFp     - dispatched entry contents
//                 ResValid/ResReady[3:0]     - per-unit result handshake
//                 ResData[4*XLEN-1:0]        - per-unit result data
//                 WbValid/WbFp/WbRd/WbData   - registered writeback port
//                 Empty                      - no entries outstanding
// Revision    : 1.0 - initial release
// ============================================================================

package completion_queue_pkg;
  typedef struct packed {
    int unsigned XLEN;
  } cvw_t;
endpackage

interface completion_queue_if #(
  parameter int XLEN = 32
);
  logic              Flush;
  logic              DispValid;
  logic              DispReady;
  logic [1:0]        DispUnit;
  logic [4:0]        DispRd;
  logic              DispFp;
  logic [3:0]        ResValid;
  logic [3:0]        ResReady;
  logic [4*XLEN-1:0] ResData;
  logic              WbValid;
  logic              WbFp;
  logic [4:0]        WbRd;
  logic [XLEN-1:0]   WbData;
  logic              Empty;

  modport slave (
    input  Flush, DispValid, DispUnit, DispRd, DispFp, ResValid, ResData,
    output DispReady, ResReady, WbValid, WbFp, WbRd, WbData, Empty
  );

  modport master (
    output Flush, DispValid, DispUnit, DispRd, DispFp, ResValid, ResData,
    input  DispReady, ResReady, WbValid, WbFp, WbRd, WbData, Empty
  );
endinterface

`default_nettype wire

// File: rtl/completion_queue.sv
`default_nettype none
// ============================================================================
// Module      : completion_queue
// Description : In-order completion queue. Records the target unit and
//               destination of each dispatched instruction, accepts results
//               only from the unit owning the oldest entry, and retires them
//               in dispatch order onto a single registered writeback port.
//               Ports:
//                 clk, reset (async, active-high)
//                 bus          - completion_queue_if.slave (all handshakes)
//               Optional (macro COMPLETION_STATS_EN):
//                 HeadStallCnt - cycles the head waits for its result
//                 RetireCnt    - per-unit retired-result counters, 32b each
// Revision    : 1.0 - initial release
// ============================================================================

module completion_queue #(
  parameter completion_queue_pkg::cvw_t P = '{XLEN: 32},
  parameter int DEPTH = 4
) (
  input  wire logic           clk,
  input  wire logic           reset,
`ifdef COMPLETION_STATS_EN
  output logic [31:0]         HeadStallCnt,
  output logic [4*32-1:0]     RetireCnt,
`endif
  completion_queue_if.slave   bus
);

  localparam int               c_xlen  = int'(P.XLEN);
  localparam int               c_aw    = $clog2(DEPTH);
  localparam logic [c_aw:0]    c_depth = (c_aw + 1)'(DEPTH);

  // Entry storage, split per field
  logic [1:0]        r_unit [DEPTH];
  logic [4:0]        r_rd   [DEPTH];
  logic              r_fp   [DEPTH];

  logic [c_aw-1:0]   r_head;
  logic [c_aw-1:0]   r_tail;
  logic [c_aw:0]     r_count;

  logic              r_wb_valid;
  logic              r_wb_fp;
  logic [4:0]        r_wb_rd;
  logic [c_xlen-1:0] r_wb_data;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_x0;
  logic [1:0]        w_head_unit;
  logic [3:0]        w_res_ready;
  logic [c_xlen-1:0] w_res [4];

  for (genvar u = 0; u < 4; u++) begin : g_res
    assign w_res[u] = bus.ResData[u*c_xlen +: c_xlen];
  end

  assign w_full      = (r_count == c_depth);
  assign w_empty     = (r_count == '0);
  assign w_head_unit = r_unit[r_head];
  // Integer x0 consumes its result but never writes back
  assign w_x0        = (r_rd[r_head] == 5'd0) & ~r_fp[r_head];

  // Only the unit owning the oldest entry is offered ready
  always_comb begin
    w_res_ready = '0;
    if (!w_empty && !bus.Flush) begin
      w_res_ready[w_head_unit] = 1'b1;
    end
  end

  assign w_pop  = |(w_res_ready & bus.ResValid);
  // Readiness depends on registered count only: no push into a full queue
  // even when a pop happens in the same cycle
  assign w_push = bus.DispValid & ~w_full & ~bus.Flush;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_unit[r_tail] <= bus.DispUnit;
      r_rd[r_tail]   <= bus.DispRd;
      r_fp[r_tail]   <= bus.DispFp;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (bus.Flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Writeback fields only move on a real strobe, so they hold otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wb_valid <= 1'b0;
      r_wb_fp    <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
    end else begin
      r_wb_valid <= w_pop & ~w_x0;
      if (w_pop && !w_x0) begin
        r_wb_fp   <= r_fp[r_head];
        r_wb_rd   <= r_rd[r_head];
        r_wb_data <= w_res[w_head_unit];
      end
    end
  end

  assign bus.DispReady = ~w_full;
  assign bus.ResReady  = w_res_ready;
  assign bus.Empty     = w_empty;
  assign bus.WbValid   = r_wb_valid;
  assign bus.WbFp      = r_wb_fp;
  assign bus.WbRd      = r_wb_rd;
  assign bus.WbData    = r_wb_data;

`ifdef COMPLETION_STATS_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (!w_empty && !bus.ResValid[w_head_unit] && !bus.Flush) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign HeadStallCnt = r_stall_cnt;

  for (genvar u = 0; u < 4; u++) begin : g_retire
    logic [31:0] r_retire_cnt;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_retire_cnt <= '0;
      end else if (w_pop && (w_head_unit == 2'(u))) begin
        r_retire_cnt <= r_retire_cnt + 32'd1;
      end
    end

    assign RetireCnt[u*32 +: 32] = r_retire_cnt;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_completion_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_completion_queue
// Description : Self-checking bench for completion_queue. A reference queue
//               of dispatched entries plus per-unit result queues model the
//               execution units; expected writebacks come from that model
//               and from a hand-computed vector table.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_completion_queue;

  localparam int c_depth = 4;

  typedef struct {
    logic [1:0]  unit;
    logic [4:0]  rd;
    logic        fp;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    logic        dv;
    logic [1:0]  unit;
    logic [4:0]  rd;
    logic        fp;
    logic [31:0] data;
    logic [3:0]  hold;
    logic        exp_wbv;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
    logic        exp_empty;
  } vec_t;

  logic clk;
  logic reset;

  completion_queue_if #(.XLEN(32)) cq();

`ifdef COMPLETION_STATS_EN
  logic [31:0]  head_stall;
  logic [127:0] retire_cnt;
`endif

  completion_queue #(.DEPTH(c_depth)) dut (
    .clk          (clk),
    .reset        (reset),
`ifdef COMPLETION_STATS_EN
    .HeadStallCnt (head_stall),
    .RetireCnt    (retire_cnt),
`endif
    .bus          (cq.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  ent_t        mq[$];
  logic [31:0] uq[4][$];
  logic        exp_wbv;
  logic        last_fp;
  logic [4:0]  last_rd;
  logic [31:0] last_data;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    for (int u = 0; u < 4; u++) uq[u].delete();
  endtask

  // One clock cycle: drive at negedge, check combinational outputs, update
  // the model at posedge, then check the registered writeback port.
  task automatic tick(input logic dv, input logic [1:0] unit, input logic [4:0] rd,
                      input logic fp, input logic [31:0] data, input logic flush,
                      input logic [3:0] hold);
    logic [3:0] rv;
    logic [3:0] exp_rr;
    logic       m_push;
    logic       m_pop;
    ent_t       e;
    @(negedge clk);
    cq.DispValid = dv;
    cq.DispUnit  = unit;
    cq.DispRd    = rd;
    cq.DispFp    = fp;
    cq.Flush     = flush;
    rv = '0;
    for (int u = 0; u < 4; u++) begin
      if (!hold[u] && uq[u].size() > 0) begin
        rv[u] = 1'b1;
        cq.ResData[u*32 +: 32] = uq[u][0];
      end else begin
        cq.ResData[u*32 +: 32] = 32'h0;
      end
    end
    cq.ResValid = rv;
    #1;
    exp_rr = (mq.size() > 0 && !flush) ? (4'b0001 << mq[0].unit) : 4'b0000;
    chk("res_ready",  64'(cq.ResReady),  64'(exp_rr));
    chk("disp_ready", 64'(cq.DispReady), 64'(mq.size() < c_depth));
    chk("empty",      64'(cq.Empty),     64'(mq.size() == 0));
    m_pop  = (mq.size() > 0) && !flush && rv[mq[0].unit];
    m_push = dv && !flush && (mq.size() < c_depth);
    @(posedge clk);
    exp_wbv = 1'b0;
    if (flush) begin
      model_clear();
    end else begin
      if (m_pop) begin
        e = mq.pop_front();
        void'(uq[e.unit].pop_front());
        if (!(e.rd == 5'd0 && !e.fp)) begin
          exp_wbv   = 1'b1;
          last_rd   = e.rd;
          last_fp   = e.fp;
          last_data = e.data;
        end
      end
      if (m_push) begin
        e.unit = unit; e.rd = rd; e.fp = fp; e.data = data;
        mq.push_back(e);
        uq[unit].push_back(data);
      end
    end
    #1;
    chk("wb_valid", 64'(cq.WbValid), 64'(exp_wbv));
    chk("wb_rd",    64'(cq.WbRd),    64'(last_rd));
    chk("wb_fp",    64'(cq.WbFp),    64'(last_fp));
    chk("wb_data",  64'(cq.WbData),  64'(last_data));
  endtask

  task automatic idle(input logic [3:0] hold);
    tick(1'b0, 2'd0, 5'd0, 1'b0, 32'h0, 1'b0, hold);
  endtask

  task automatic drain();
    for (int k = 0; k < 24 && mq.size() > 0; k++) idle(4'b0000);
    idle(4'b0000);
    chk("drain_empty", 64'(cq.Empty), 64'd1);
  endtask

  initial begin
    reset        = 1'b1;
    cq.Flush     = 1'b0;
    cq.DispValid = 1'b0;
    cq.DispUnit  = 2'd0;
    cq.DispRd    = 5'd0;
    cq.DispFp    = 1'b0;
    cq.ResValid  = 4'b0;
    cq.ResData   = '0;
    exp_wbv      = 1'b0;
    last_fp      = 1'b0;
    last_rd      = 5'd0;
    last_data    = 32'h0;

    // In-order retire: MDU result ready early but held behind ALU rd=5
    tbl[0] = '{1'b1, 2'd0, 5'd5, 1'b0, 32'h0000_00AA, 4'b0001, 1'b0, 5'd0, 32'h0,         1'b0};
    tbl[1] = '{1'b1, 2'd1, 5'd6, 1'b0, 32'h0000_1234, 4'b0001, 1'b0, 5'd0, 32'h0,         1'b0};
    tbl[2] = '{1'b1, 2'd0, 5'd7, 1'b0, 32'h0000_00BB, 4'b0001, 1'b0, 5'd0, 32'h0,         1'b0};
    tbl[3] = '{1'b0, 2'd0, 5'd0, 1'b0, 32'h0,         4'b0001, 1'b0, 5'd0, 32'h0,         1'b0};
    tbl[4] = '{1'b0, 2'd0, 5'd0, 1'b0, 32'h0,         4'b0000, 1'b1, 5'd5, 32'h0000_00AA, 1'b0};
    tbl[5] = '{1'b0, 2'd0, 5'd0, 1'b0, 32'h0,         4'b0000, 1'b1, 5'd6, 32'h0000_1234, 1'b0};
    tbl[6] = '{1'b0, 2'd0, 5'd0, 1'b0, 32'h0,         4'b0000, 1'b1, 5'd7, 32'h0000_00BB, 1'b1};
    tbl[7] = '{1'b0, 2'd0, 5'd0, 1'b0, 32'h0,         4'b0000, 1'b0, 5'd7, 32'h0000_00BB, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_wb_valid",   64'(cq.WbValid),   64'd0);
    chk("rst_empty",      64'(cq.Empty),     64'd1);
    chk("rst_disp_ready", 64'(cq.DispReady), 64'd1);
    chk("rst_res_ready",  64'(cq.ResReady),  64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Reset then idle
    for (int i = 0; i < 10; i++) idle(4'b0000);

    // Table-driven in-order retire
    for (int i = 0; i < 8; i++) begin
      tick(tbl[i].dv, tbl[i].unit, tbl[i].rd, tbl[i].fp, tbl[i].data, 1'b0, tbl[i].hold);
      chk($sformatf("tbl%0d_wbv", i),   64'(cq.WbValid), 64'(tbl[i].exp_wbv));
      chk($sformatf("tbl%0d_empty", i), 64'(cq.Empty),   64'(tbl[i].exp_empty));
      if (tbl[i].exp_wbv) begin
        chk($sformatf("tbl%0d_rd", i),   64'(cq.WbRd),   64'(tbl[i].exp_rd));
        chk($sformatf("tbl%0d_data", i), 64'(cq.WbData), 64'(tbl[i].exp_data));
      end
    end

    // Full: four entries with no results, fifth refused, no bypass on pop
    for (int i = 0; i < 4; i++)
      tick(1'b1, 2'd0, 5'(i + 1), 1'b0, 32'h10 + 32'(i), 1'b0, 4'b1111);
    tick(1'b1, 2'd0, 5'd20, 1'b0, 32'hDEAD, 1'b0, 4'b1111);
    tick(1'b1, 2'd0, 5'd21, 1'b0, 32'hBEEF, 1'b0, 4'b0000);
    chk("full_pop_rd", 64'(cq.WbRd), 64'd1);
    tick(1'b1, 2'd0, 5'd9, 1'b0, 32'h99, 1'b0, 4'b1111);
    tick(1'b0, 2'd0, 5'd0, 1'b0, 32'h0, 1'b0, 4'b1111);
    chk("full_again", 64'(cq.DispReady), 64'd0);
    drain();
    chk("full_last_rd", 64'(cq.WbRd), 64'd9);

    // Simultaneous push/pop at count 2, pointers wrap
    tick(1'b1, 2'd0, 5'd10, 1'b0, 32'h100, 1'b0, 4'b1111);
    tick(1'b1, 2'd1, 5'd11, 1'b1, 32'h101, 1'b0, 4'b1111);
    for (int i = 2; i < 10; i++)
      tick(1'b1, 2'(i % 4), 5'(10 + i), 1'(i % 2), 32'h100 + 32'(i), 1'b0, 4'b0000);
    drain();

    // Flush with three entries, FPU head presenting its result
    tick(1'b1, 2'd2, 5'd3, 1'b1, 32'h33, 1'b0, 4'b1111);
    tick(1'b1, 2'd0, 5'd4, 1'b0, 32'h44, 1'b0, 4'b1111);
    tick(1'b1, 2'd1, 5'd8, 1'b0, 32'h88, 1'b0, 4'b1111);
    tick(1'b1, 2'd0, 5'd2, 1'b0, 32'h66, 1'b1, 4'b0000);
    chk("flush_empty", 64'(cq.Empty), 64'd1);
    tick(1'b1, 2'd0, 5'd1, 1'b0, 32'h55, 1'b0, 4'b0000);
    idle(4'b0000);
    chk("flush_after_rd",   64'(cq.WbRd),   64'd1);
    chk("flush_after_data", 64'(cq.WbData), 64'h55);

    // x0 integer destination and FP x0 destination
    tick(1'b1, 2'd0, 5'd0, 1'b0, 32'h11, 1'b0, 4'b0000);
    tick(1'b1, 2'd2, 5'd0, 1'b1, 32'h22, 1'b0, 4'b0000);
    chk("x0_no_wb", 64'(cq.WbValid), 64'd0);
    idle(4'b0000);
    chk("fp0_wbv",  64'(cq.WbValid), 64'd1);
    chk("fp0_data", 64'(cq.WbData),  64'h22);
    idle(4'b0000);

    // Asynchronous reset mid-operation
    tick(1'b1, 2'd3, 5'd12, 1'b0, 32'h77, 1'b0, 4'b1111);
    tick(1'b1, 2'd3, 5'd13, 1'b0, 32'h78, 1'b0, 4'b1111);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_empty", 64'(cq.Empty),     64'd1);
    chk("async_rst_ready", 64'(cq.DispReady), 64'd1);
    chk("async_rst_wbrd",  64'(cq.WbRd),      64'd0);
    model_clear();
    last_rd   = 5'd0;
    last_fp   = 1'b0;
    last_data = 32'h0;
    cq.DispValid = 1'b0;
    cq.ResValid  = 4'b0;
    @(negedge clk);
    reset = 1'b0;
    tick(1'b1, 2'd1, 5'd14, 1'b0, 32'hC0DE, 1'b0, 4'b0000);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
